// File: rtl/aes_pkg.sv
// Shared AES core definitions: word type, requester indices and sizes.
package aes_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_LANES = WORD_W / BYTE_W;

    localparam int unsigned REQ_DATA = 0;
    localparam int unsigned REQ_KEY  = 1;
    localparam int unsigned NUM_REQ  = 2;

    typedef logic [WORD_W-1:0] aes_word_t;

    // Response register occupancy; FULL means rsp_valid is asserted for the owner.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/sbox_byte.sv
// AES forward S-box, one byte, table lookup.
module sbox_byte
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_in,
    output logic [BYTE_W-1:0] byte_out
);

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign byte_out = SBOX_TABLE[byte_in];

endmodule

// File: rtl/sbox_word.sv
// SubWord: four independent byte S-boxes, no rotation.
module sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out
);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        sbox_byte u_byte (
            .byte_in  (word_in[BYTE_W*k +: BYTE_W]),
            .byte_out (word_out[BYTE_W*k +: BYTE_W])
        );
    end

endmodule

// File: rtl/sbox_share_arb.sv
// Round-robin sharing of one SubWord unit between the round datapath and key expansion,
// with a single-entry registered response that can drain and refill in the same cycle.
module sbox_share_arb
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  logic [WORD_W-1:0]   req_word0,
    input  logic [WORD_W-1:0]   req_word1,
    output logic [NUM_REQ-1:0]  rsp_valid,
    input  logic [NUM_REQ-1:0]  rsp_ready,
    output logic [WORD_W-1:0]   rsp_word,
    output logic                busy
);

    rsp_state_t state;
    logic       owner;
    logic       last_grant;
    aes_word_t  data;

    logic       grant;
    logic       can_acc;
    logic       drain;
    logic       accept;
    aes_word_t  sel_word;
    aes_word_t  sub_word;

    // Lone requester wins; on contention the one not served last time wins.
    always_comb begin
        grant = 1'(REQ_DATA);
        case (req_valid)
            2'b11:   grant = ~last_grant;
            2'b10:   grant = 1'(REQ_KEY);
            default: grant = 1'(REQ_DATA);
        endcase
    end

    assign drain   = (state == RSP_FULL) && rsp_ready[owner];
    assign can_acc = (state == RSP_EMPTY) || rsp_ready[owner];
    assign accept  = can_acc && (|req_valid);

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = can_acc && req_valid[grant];
    end

    assign sel_word = (grant == 1'(REQ_KEY)) ? req_word1 : req_word0;

    sbox_word u_sbox_word (
        .word_in  (sel_word),
        .word_out (sub_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RSP_EMPTY;
            owner      <= 1'(REQ_DATA);
            last_grant <= 1'(REQ_KEY);
            data       <= '0;
        end else if (accept) begin
            state      <= RSP_FULL;
            owner      <= grant;
            last_grant <= grant;
            data       <= sub_word;
        end else if (drain) begin
            state      <= RSP_EMPTY;
        end
    end

    assign rsp_valid = (state == RSP_FULL) ? (NUM_REQ'(1) << owner) : '0;
    assign rsp_word  = data;
    assign busy      = (state == RSP_FULL);

endmodule

// File: tb/tb_sbox_share_arb.sv
// Scoreboard bench for sbox_share_arb; S-box reference built from GF(2^8) inverse + affine map.
module tb_sbox_share_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [31:0] req_word0 = '0;
    logic [31:0] req_word1 = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_word;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        owner;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [1:0]  mon_v;
    logic [7:0]  model_tbl [256];

    sbox_share_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_word0 (req_word0),
        .req_word1 (req_word1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_word  (rsp_word),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_model(input logic [31:0] w);
        return {model_tbl[w[31:24]], model_tbl[w[23:16]], model_tbl[w[15:8]], model_tbl[w[7:0]]};
    endfunction

    function automatic exp_t mk(input logic owner, input logic [31:0] w);
        exp_t e;
        e.owner = owner;
        e.word  = sub_model(w);
        return e;
    endfunction

    // Response monitor: every visible response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rsp_valid !== 2'b00) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected got valid=%b word=%h, none expected", rsp_valid, rsp_word);
            end else begin
                mon_e = sb[0];
                mon_v = mon_e.owner ? 2'b10 : 2'b01;
                if (rsp_valid !== mon_v || rsp_word !== mon_e.word) begin
                    fails++;
                    $display("FAIL rsp_data got valid=%b word=%h, expected valid=%b word=%h",
                             rsp_valid, rsp_word, mon_v, mon_e.word);
                end
                if ((mon_v & rsp_ready) != 2'b00) void'(sb.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        sb.delete();
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain_all(input string name);
        req_valid = '0;
        rsp_ready = 2'b11;
        for (int i = 0; i < 6 && sb.size() != 0; i++) next_cycle();
        next_cycle();
        tests++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_drain got pending=%0d busy=%b, expected pending=0 busy=0", name, sb.size(), busy);
        end
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (rsp_valid !== 2'b00 || rsp_word !== 32'h0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got valid=%b word=%h busy=%b, expected 00/0/0", rsp_valid, rsp_word, busy);
        end
    endtask

    task automatic test_single();
        req_valid = 2'b01;
        req_word0 = 32'h00010253;
        rsp_ready = 2'b01;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL single_ready got %b, expected 01", req_ready);
        end
        sb.push_back(mk(1'b0, req_word0));
        next_cycle();
        req_valid = 2'b00;
        tests++;
        if (rsp_valid !== 2'b01 || rsp_word !== 32'h637c77ed) begin
            fails++;
            $display("FAIL single_latency got valid=%b word=%h, expected 01 637c77ed", rsp_valid, rsp_word);
        end
        drain_all("single");
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy;
        do_reset();
        req_valid = 2'b11;
        req_word0 = 32'hff095200;
        req_word1 = 32'h00000000;
        rsp_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests++;
            if (req_ready !== exp_rdy) begin
                fails++;
                $display("FAIL contention_grant%0d got %b, expected %b", k, req_ready, exp_rdy);
            end
            sb.push_back(mk(exp_rdy[1], exp_rdy[1] ? req_word1 : req_word0));
            next_cycle();
        end
        tests++;
        if (rsp_word !== 32'h63636363 || rsp_valid !== 2'b10) begin
            fails++;
            $display("FAIL contention_last got valid=%b word=%h, expected 10 63636363", rsp_valid, rsp_word);
        end
        drain_all("contention");
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 2'b10;
        req_word1 = 32'h00000000;
        rsp_ready = 2'b00;
        #1;
        sb.push_back(mk(1'b1, req_word1));
        next_cycle();
        req_valid = 2'b01;
        req_word0 = 32'h00010253;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++;
            if (req_ready !== 2'b00 || rsp_word !== 32'h63636363 || rsp_valid !== 2'b10) begin
                fails++;
                $display("FAIL stall%0d got ready=%b valid=%b word=%h, expected 00 10 63636363",
                         k, req_ready, rsp_valid, rsp_word);
            end
            next_cycle();
        end
        rsp_ready = 2'b10;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL stall_release_ready got %b, expected 01", req_ready);
        end
        sb.push_back(mk(1'b0, req_word0));
        next_cycle();
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        tests++;
        if (rsp_valid !== 2'b01 || rsp_word !== 32'h637c77ed) begin
            fails++;
            $display("FAIL no_bubble got valid=%b word=%h, expected 01 637c77ed", rsp_valid, rsp_word);
        end
        drain_all("backpressure");
    endtask

    task automatic test_wrong_owner();
        do_reset();
        req_valid = 2'b01;
        req_word0 = 32'h00010253;
        rsp_ready = 2'b00;
        #1;
        sb.push_back(mk(1'b0, req_word0));
        next_cycle();
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            tests++;
            if (busy !== 1'b1 || rsp_valid !== 2'b01) begin
                fails++;
                $display("FAIL wrong_owner%0d got busy=%b valid=%b, expected 1 01", k, busy, rsp_valid);
            end
        end
        drain_all("wrong_owner");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 2'b01;
        req_word0 = 32'h00010253;
        rsp_ready = 2'b00;
        #1;
        sb.push_back(mk(1'b0, req_word0));
        next_cycle();
        req_valid = 2'b00;
        tests++;
        if (busy !== 1'b1 || rsp_word !== 32'h637c77ed) begin
            fails++;
            $display("FAIL midflight_pre got busy=%b word=%h, expected 1 637c77ed", busy, rsp_word);
        end
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        tests++;
        if (rsp_valid !== 2'b00 || rsp_word !== 32'h0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got valid=%b word=%h busy=%b, expected 00/0/0", rsp_valid, rsp_word, busy);
        end
        next_cycle();
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_word0 = 32'hff095200;
        req_word1 = 32'h00000000;
        rsp_ready = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL post_reset_grant got %b, expected 01", req_ready);
        end
        sb.push_back(mk(1'b0, req_word0));
        next_cycle();
        drain_all("midflight");
    endtask

    task automatic test_exhaustive();
        logic [7:0] b;
        do_reset();
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            req_word1 = {b + 8'd3, b + 8'd2, b + 8'd1, b};
            #1;
            tests++;
            if (req_ready !== 2'b10) begin
                fails++;
                $display("FAIL stream_ready%0d got %b, expected 10", i, req_ready);
            end
            sb.push_back(mk(1'b1, req_word1));
            next_cycle();
        end
        drain_all("exhaustive");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_tbl[i] = sbox_ref(8'(i));
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_wrong_owner();
        test_reset_midflight();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
